// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: FSM state, tracked-branch entry
// and the BHT index width derived from the BHT left/right range macro.
`ifndef BHT_LR_WIDTH
`define BHT_LR_WIDTH 7:0
`endif

package bru_pkg;

  localparam int BHT_IDX_W = $bits(logic [`BHT_LR_WIDTH]);

  typedef enum logic {
    RUN,
    RECOVER
  } bru_state_e;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] bht_id;
    logic                 pred_taken;
    logic [31:0]          alt_pc;
  } bru_entry_t;

endpackage

// File: rtl/bru_fifo.sv
// Branch-tracking FIFO: storage, wrapping head/tail pointers and an
// independent occupancy counter, with a synchronous clear for mispredicts.
module bru_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  bru_entry_t               wr_entry,
  output bru_entry_t               rd_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bru_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[tail] <= wr_entry;
    end
  end

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_entry = mem[head];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves predicted conditional branches at ROB commit, drives BHT update
// pulses and issues a fetch redirect on a mispredict.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = BHT_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     iq_push,
  input  logic [IDX_W-1:0]         iq_bht_id,
  input  logic                     iq_pred_taken,
  input  logic [31:0]              iq_alt_pc,
  output logic                     br_full,
  input  logic                     rob_commit,
  input  logic                     rob_taken,
  output logic                     ROB_to_BHT_needchange,
  output logic                     ROB_to_BHT_needchange2,
  output logic [IDX_W-1:0]         bht_id2,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   br_count,
  output logic                     err_underflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  bru_state_e        state;
  bru_state_e        state_nxt;
  bru_entry_t        head_entry;
  bru_entry_t        push_entry;
  logic [CNT_W-1:0]  count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              commit_ok;
  logic              mispredict;
  logic              correct;
  logic              underflow;
  logic              push_acc;
  logic              pop_en;
  logic              clear;
  logic              needchange_nxt;
  logic              needchange2_nxt;
  logic              redirect_nxt;
  logic              br_full_nxt;

  assign commit_ok  = rdy && rob_commit && !fifo_empty;
  assign mispredict = commit_ok && (rob_taken != head_entry.pred_taken);
  assign correct    = commit_ok && !mispredict;
  assign underflow  = rdy && rob_commit && fifo_empty;
  // A push alongside a mispredict is wrong-path, so the clear wins.
  assign push_acc   = rdy && iq_push && (state == RUN) && !fifo_full && !mispredict;
  assign pop_en     = correct;
  assign clear      = mispredict;

  assign push_entry.bht_id     = iq_bht_id;
  assign push_entry.pred_taken = iq_pred_taken;
  assign push_entry.alt_pc     = iq_alt_pc;

  bru_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_acc),
    .pop      (pop_en),
    .clear    (clear),
    .wr_entry (push_entry),
    .rd_entry (head_entry),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mispredict) state_nxt = RECOVER;
      RECOVER: if (rdy)        state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // br_full must reflect the post-edge occupancy, so it is predicted here.
  always_comb begin
    needchange_nxt  = mispredict;
    needchange2_nxt = correct;
    redirect_nxt    = mispredict;
    br_full_nxt     = (state_nxt == RECOVER) ||
                      (!clear && fifo_full && !pop_en) ||
                      (!clear && (count == CNT_W'(DEPTH - 1)) && push_acc && !pop_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ROB_to_BHT_needchange  <= 1'b0;
      ROB_to_BHT_needchange2 <= 1'b0;
      redirect_valid         <= 1'b0;
      bht_id2                <= '0;
      redirect_pc            <= '0;
      br_full                <= 1'b0;
      err_underflow          <= 1'b0;
    end else begin
      ROB_to_BHT_needchange  <= needchange_nxt;
      ROB_to_BHT_needchange2 <= needchange2_nxt;
      redirect_valid         <= redirect_nxt;
      if (commit_ok)  bht_id2     <= head_entry.bht_id;
      if (mispredict) redirect_pc <= head_entry.alt_pc;
      if (rdy)        br_full     <= br_full_nxt;
      if (underflow)  err_underflow <= 1'b1;
    end
  end

  assign br_count = count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed table-driven bench for branch_resolve_unit plus hand-written
// sequences for fill/full, pointer wrap and asynchronous reset.
module tb_branch_resolve_unit;

  localparam int DEPTH = 16;
  localparam int IDX_W = 8;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             iq_push;
  logic [IDX_W-1:0] iq_bht_id;
  logic             iq_pred_taken;
  logic [31:0]      iq_alt_pc;
  logic             br_full;
  logic             rob_commit;
  logic             rob_taken;
  logic             needchange;
  logic             needchange2;
  logic [IDX_W-1:0] bht_id2;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_count;
  logic             err_underflow;

  int total = 0;
  int bad   = 0;

  branch_resolve_unit #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rdy                    (rdy),
    .iq_push                (iq_push),
    .iq_bht_id              (iq_bht_id),
    .iq_pred_taken          (iq_pred_taken),
    .iq_alt_pc              (iq_alt_pc),
    .br_full                (br_full),
    .rob_commit             (rob_commit),
    .rob_taken              (rob_taken),
    .ROB_to_BHT_needchange  (needchange),
    .ROB_to_BHT_needchange2 (needchange2),
    .bht_id2                (bht_id2),
    .redirect_valid         (redirect_valid),
    .redirect_pc            (redirect_pc),
    .br_count               (br_count),
    .err_underflow          (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        push;
    logic [7:0]  id;
    logic        pred;
    logic [31:0] alt;
    logic        commit;
    logic        taken;
    logic        nc;
    logic        nc2;
    logic        redir;
    logic [7:0]  id2;
    logic [31:0] pc;
    logic        full;
    logic [4:0]  count;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic r, input logic push, input logic [7:0] id,
                               input logic pred, input logic [31:0] alt,
                               input logic commit, input logic taken);
    rdy           = r;
    iq_push       = push;
    iq_bht_id     = id;
    iq_pred_taken = pred;
    iq_alt_pc     = alt;
    rob_commit    = commit;
    rob_taken     = taken;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyInputsIdle();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic applyInputsIdle();
    rdy           = 1'b1;
    iq_push       = 1'b0;
    iq_bht_id     = '0;
    iq_pred_taken = 1'b0;
    iq_alt_pc     = '0;
    rob_commit    = 1'b0;
    rob_taken     = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1, 1, 8'h05, 1, 32'h1000, 0, 0,  0, 0, 0, 8'h00, 32'h0,    0, 5'd1, 0};
    vecs[1]  = '{1, 0, 8'h00, 0, 32'h0,    1, 1,  0, 1, 0, 8'h05, 32'h0,    0, 5'd0, 0};
    vecs[2]  = '{1, 1, 8'h09, 0, 32'h2040, 0, 0,  0, 0, 0, 8'h05, 32'h0,    0, 5'd1, 0};
    vecs[3]  = '{1, 0, 8'h00, 0, 32'h0,    1, 1,  1, 0, 1, 8'h09, 32'h2040, 1, 5'd0, 0};
    vecs[4]  = '{1, 1, 8'h03, 1, 32'h0,    0, 0,  0, 0, 0, 8'h09, 32'h2040, 0, 5'd0, 0};
    vecs[5]  = '{1, 0, 8'h00, 0, 32'h0,    1, 0,  0, 0, 0, 8'h09, 32'h2040, 0, 5'd0, 1};
    vecs[6]  = '{1, 1, 8'h07, 0, 32'h3000, 0, 0,  0, 0, 0, 8'h09, 32'h2040, 0, 5'd1, 1};
    vecs[7]  = '{0, 0, 8'h00, 0, 32'h0,    1, 0,  0, 0, 0, 8'h09, 32'h2040, 0, 5'd1, 1};
    vecs[8]  = '{1, 0, 8'h00, 0, 32'h0,    1, 0,  0, 1, 0, 8'h07, 32'h2040, 0, 5'd0, 1};
    vecs[9]  = '{1, 1, 8'h20, 1, 32'h500,  0, 0,  0, 0, 0, 8'h07, 32'h2040, 0, 5'd1, 1};
    vecs[10] = '{1, 1, 8'h21, 0, 32'h600,  1, 0,  1, 0, 1, 8'h20, 32'h500,  1, 5'd0, 1};
    vecs[11] = '{1, 0, 8'h00, 0, 32'h0,    0, 0,  0, 0, 0, 8'h20, 32'h500,  0, 5'd0, 1};
    vecs[12] = '{1, 0, 8'h00, 0, 32'h0,    1, 1,  0, 0, 0, 8'h20, 32'h500,  0, 5'd0, 1};

    // Reset values, sampled while reset is still asserted
    rst = 1'b1;
    applyInputsIdle();
    #12;
    checkOutput("rst.nc",    {31'b0, needchange},     0);
    checkOutput("rst.nc2",   {31'b0, needchange2},    0);
    checkOutput("rst.redir", {31'b0, redirect_valid}, 0);
    checkOutput("rst.id2",   {24'b0, bht_id2},        0);
    checkOutput("rst.pc",    redirect_pc,             0);
    checkOutput("rst.full",  {31'b0, br_full},        0);
    checkOutput("rst.count", {27'b0, br_count},       0);
    checkOutput("rst.err",   {31'b0, err_underflow},  0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rdy, vecs[i].push, vecs[i].id, vecs[i].pred, vecs[i].alt,
                    vecs[i].commit, vecs[i].taken);
      checkOutput($sformatf("v%0d.nc", i),    {31'b0, needchange},     {31'b0, vecs[i].nc});
      checkOutput($sformatf("v%0d.nc2", i),   {31'b0, needchange2},    {31'b0, vecs[i].nc2});
      checkOutput($sformatf("v%0d.redir", i), {31'b0, redirect_valid}, {31'b0, vecs[i].redir});
      checkOutput($sformatf("v%0d.id2", i),   {24'b0, bht_id2},        {24'b0, vecs[i].id2});
      checkOutput($sformatf("v%0d.pc", i),    redirect_pc,             vecs[i].pc);
      checkOutput($sformatf("v%0d.full", i),  {31'b0, br_full},        {31'b0, vecs[i].full});
      checkOutput($sformatf("v%0d.count", i), {27'b0, br_count},       {27'b0, vecs[i].count});
      checkOutput($sformatf("v%0d.err", i),   {31'b0, err_underflow},  {31'b0, vecs[i].err});
    end

    // Fill to DEPTH, overflow push, then push+commit while full and at DEPTH-1
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 1, 8'(8'h40 + i), 1, 32'(32'h100 + i), 0, 0);
      checkOutput($sformatf("fill%0d.count", i), {27'b0, br_count}, 32'(i + 1));
      checkOutput($sformatf("fill%0d.full", i),  {31'b0, br_full},  {31'b0, (i == DEPTH - 1)});
    end
    applyStimulus(1, 1, 8'h99, 1, 32'h0, 0, 0);
    checkOutput("ovf.count", {27'b0, br_count}, 16);
    checkOutput("ovf.full",  {31'b0, br_full},  1);
    applyStimulus(1, 1, 8'h98, 1, 32'h0, 1, 1);
    checkOutput("fullpc.count", {27'b0, br_count},    15);
    checkOutput("fullpc.nc2",   {31'b0, needchange2}, 1);
    checkOutput("fullpc.id2",   {24'b0, bht_id2},     32'h40);
    checkOutput("fullpc.full",  {31'b0, br_full},     0);
    applyStimulus(1, 1, 8'h80, 1, 32'h0, 1, 1);
    checkOutput("pc15.count", {27'b0, br_count}, 15);
    checkOutput("pc15.id2",   {24'b0, bht_id2},  32'h41);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 0, 8'h00, 0, 32'h0, 1, 1);
      checkOutput($sformatf("drain%0d.nc2", i), {31'b0, needchange2}, 1);
      checkOutput($sformatf("drain%0d.id2", i), {24'b0, bht_id2},
                  (i < 14) ? 32'(32'h42 + i) : 32'h80);
    end
    checkOutput("drain.count", {27'b0, br_count}, 0);

    // Pointer wrap-around: 40 correct push/commit pairs
    doReset();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 8'(i), 1'(i), 32'(32'h8000 + 4 * i), 0, 0);
      applyStimulus(1, 0, 8'h00, 0, 32'h0, 1, 1'(i));
      checkOutput($sformatf("wrap%0d.nc2", i), {31'b0, needchange2}, 1);
      checkOutput($sformatf("wrap%0d.id2", i), {24'b0, bht_id2},     32'(i));
    end
    checkOutput("wrap.err",   {31'b0, err_underflow}, 0);
    checkOutput("wrap.count", {27'b0, br_count},      0);

    // Asynchronous reset while a mispredict pulse is in flight
    applyStimulus(1, 1, 8'h33, 1, 32'h7000, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 32'h0, 1, 0);
    checkOutput("pre.nc",    {31'b0, needchange},     1);
    checkOutput("pre.redir", {31'b0, redirect_valid}, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst.nc",    {31'b0, needchange},     0);
    checkOutput("arst.redir", {31'b0, redirect_valid}, 0);
    checkOutput("arst.id2",   {24'b0, bht_id2},        0);
    checkOutput("arst.pc",    redirect_pc,             0);
    checkOutput("arst.full",  {31'b0, br_full},        0);
    rob_commit = 1'b0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 8'h00, 0, 32'h0, 0, 0);
      checkOutput($sformatf("post%0d.nc", i),  {31'b0, needchange},  0);
      checkOutput($sformatf("post%0d.nc2", i), {31'b0, needchange2}, 0);
      checkOutput($sformatf("post%0d.full", i), {31'b0, br_full},    0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
